// File: rtl/wb_queue_if.sv
// ============================================================================
// Module      : wb_queue_if
// Description : Writeback queue bus: producer handshakes, register-file write
//               port and decode lookup ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_queue_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  logic                         alu_valid_ip;
  logic [ADDR_WIDTH-1:0]        alu_addr_ip;
  logic [DATA_WIDTH-1:0]        alu_data_ip;
  logic                         alu_ready_op;
  logic                         lsu_valid_ip;
  logic [ADDR_WIDTH-1:0]        lsu_addr_ip;
  logic [DATA_WIDTH-1:0]        lsu_data_ip;
  logic                         lsu_ready_op;
  logic [ADDR_WIDTH-1:0]        waddr_a_op;
  logic [DATA_WIDTH-1:0]        wdata_a_op;
  logic                         we_a_op;
  logic [ADDR_WIDTH-1:0]        raddr_a_ip;
  logic [ADDR_WIDTH-1:0]        raddr_b_ip;
  logic                         hit_a_op;
  logic                         hit_b_op;
  logic [DATA_WIDTH-1:0]        fwd_a_op;
  logic [DATA_WIDTH-1:0]        fwd_b_op;
  logic [$clog2(DEPTH):0]       count_op;

  modport master (
    output alu_valid_ip, alu_addr_ip, alu_data_ip,
    input  alu_ready_op,
    output lsu_valid_ip, lsu_addr_ip, lsu_data_ip,
    input  lsu_ready_op,
    input  waddr_a_op, wdata_a_op, we_a_op,
    output raddr_a_ip, raddr_b_ip,
    input  hit_a_op, hit_b_op, fwd_a_op, fwd_b_op,
    input  count_op
  );

  modport slave (
    input  alu_valid_ip, alu_addr_ip, alu_data_ip,
    output alu_ready_op,
    input  lsu_valid_ip, lsu_addr_ip, lsu_data_ip,
    output lsu_ready_op,
    output waddr_a_op, wdata_a_op, we_a_op,
    input  raddr_a_ip, raddr_b_ip,
    output hit_a_op, hit_b_op, fwd_a_op, fwd_b_op,
    output count_op
  );
endinterface

`default_nettype wire

// File: rtl/wb_queue.sv
// ============================================================================
// Module      : wb_queue
// Description : In-order writeback FIFO with ALU-priority arbitration, one
//               register-file write per cycle and two forwarding lookups.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_queue #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  wire         clock,
  input  wire         reset,
  wb_queue_if.slave   bus
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [c_PTR_W-1:0]    r_head;
  logic [c_PTR_W-1:0]    r_tail;
  logic [c_CNT_W-1:0]    r_count;

  logic                  w_not_full;
  logic                  w_alu_fire;
  logic                  w_lsu_fire;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_enq_addr;
  logic [DATA_WIDTH-1:0] w_enq_data;
  logic [DATA_WIDTH:0]   w_look_a;
  logic [DATA_WIDTH:0]   w_look_b;

  // Ready is a function of registered occupancy only, never of the same-cycle pop.
  assign w_not_full       = (r_count != c_FULL);
  assign bus.alu_ready_op = w_not_full;
  assign bus.lsu_ready_op = w_not_full & ~bus.alu_valid_ip;

  assign w_alu_fire = bus.alu_valid_ip & bus.alu_ready_op;
  assign w_lsu_fire = bus.lsu_valid_ip & bus.lsu_ready_op;
  assign w_enq_addr = w_alu_fire ? bus.alu_addr_ip : bus.lsu_addr_ip;
  assign w_enq_data = w_alu_fire ? bus.alu_data_ip : bus.lsu_data_ip;

  // Writes to r0 complete their handshake but are dropped here.
  assign w_push = (w_alu_fire | w_lsu_fire) & (w_enq_addr != '0);
  assign w_pop  = (r_count != '0);

  assign bus.we_a_op    = w_pop;
  assign bus.waddr_a_op = w_pop ? r_addr[r_head] : '0;
  assign bus.wdata_a_op = w_pop ? r_data[r_head] : '0;
  assign bus.count_op   = r_count;

  // Scan oldest to youngest so the youngest match is the one that sticks.
  function automatic logic [DATA_WIDTH:0] f_lookup(input logic [ADDR_WIDTH-1:0] raddr);
    logic [DATA_WIDTH:0] res;
    logic [c_PTR_W-1:0]  idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_head + c_PTR_W'(i);
      if ((c_CNT_W'(i) < r_count) && (r_addr[idx] == raddr) && (raddr != '0))
        res = {1'b1, r_data[idx]};
    end
    return res;
  endfunction

  always_comb begin
    w_look_a = f_lookup(bus.raddr_a_ip);
    w_look_b = f_lookup(bus.raddr_b_ip);
  end

  assign bus.hit_a_op = w_look_a[DATA_WIDTH];
  assign bus.fwd_a_op = w_look_a[DATA_WIDTH-1:0];
  assign bus.hit_b_op = w_look_b[DATA_WIDTH];
  assign bus.fwd_b_op = w_look_b[DATA_WIDTH-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_addr[r_tail] <= w_enq_addr;
        r_data[r_tail] <= w_enq_data;
        r_tail         <= r_tail + c_PTR_W'(1);
      end
      if (w_pop)
        r_head <= r_head + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire
